// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA message sequencer: FSM states, result
// error bit positions and the default WAIT timeout.
package rsa_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_GUARD,
        S_WAIT,
        S_OUT
    } seq_state_t;

    // Bit positions inside res_err.
    localparam int ERR_TIMEOUT = 0;
    localparam int ERR_RANGE   = 1;

    // Worst-case core run is one step per exponent value plus a small margin.
    function automatic int timeout_default(input int expo_w);
        return (1 << expo_w) + 4;
    endfunction

endpackage

// File: rtl/rsa_seq_timer.sv
// Counts cycles spent in WAIT; expired is high during the TIMEOUT-th cycle.
module rsa_seq_timer
    import rsa_pkg::*;
#(
    parameter int TIMEOUT = 68
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count;

    // Count while not cleared; hold once the limit is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (!expired) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/rsa_msg_sequencer.sv
// Control stage in front of the RSA modexp core: holds the public key,
// accepts plaintext blocks, launches the core, supervises it with a guard
// cycle and a timeout, and presents the result over a valid/ready stream.
module rsa_msg_sequencer
    import rsa_pkg::*;
#(
    parameter int BASE_W  = 6,
    parameter int EXPO_W  = 6,
    parameter int N_W     = 6,
    parameter int TIMEOUT = timeout_default(EXPO_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_load,
    input  logic [EXPO_W-1:0] key_expo,
    input  logic [N_W-1:0]    key_n,
    output logic              key_err,
    output logic              key_ok,
    input  logic              msg_valid,
    output logic              msg_ready,
    input  logic [BASE_W-1:0] msg_data,
    output logic [BASE_W-1:0] core_base,
    output logic [EXPO_W-1:0] core_expo,
    output logic [N_W-1:0]    core_n,
    output logic              core_start,
    input  logic [N_W-1:0]    core_result,
    input  logic              core_valid,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [N_W-1:0]    res_data,
    output logic [1:0]        res_err,
    output logic              busy
);

    localparam int CMP_W = (BASE_W > N_W) ? BASE_W : N_W;

    seq_state_t        state;
    logic [EXPO_W-1:0] held_expo;
    logic [N_W-1:0]    held_n;
    logic              expired;
    logic [CMP_W-1:0]  msg_ext;
    logic [CMP_W-1:0]  n_ext;
    logic              out_of_range;

    // Zero-extend both sides so the range check works for any width mix.
    assign msg_ext      = CMP_W'(msg_data);
    assign n_ext        = CMP_W'(held_n);
    assign out_of_range = (msg_ext >= n_ext);

    // A key load in the same cycle blocks acceptance.
    assign msg_ready = (state == S_IDLE) && key_ok && !key_load;
    assign busy      = (state != S_IDLE);
    assign core_expo = held_expo;
    assign core_n    = held_n;

    rsa_seq_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state != S_WAIT),
        .expired (expired)
    );

    // Key handling and sequencing FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            held_expo  <= '0;
            held_n     <= '0;
            key_ok     <= 1'b0;
            key_err    <= 1'b0;
            core_base  <= '0;
            core_start <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_err    <= '0;
        end else begin
            key_err    <= 1'b0;
            core_start <= 1'b0;

            if (key_load) begin
                if (state != S_IDLE) begin
                    key_err <= 1'b1;
                end else if (key_n == '0) begin
                    key_err <= 1'b1;
                    key_ok  <= 1'b0;
                end else begin
                    held_expo <= key_expo;
                    held_n    <= key_n;
                    key_ok    <= 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (msg_valid && msg_ready) begin
                        if (out_of_range) begin
                            res_data           <= '0;
                            res_err            <= '0;
                            res_err[ERR_RANGE] <= 1'b1;
                            res_valid          <= 1'b1;
                            state              <= S_OUT;
                        end else begin
                            core_base  <= msg_data;
                            core_start <= 1'b1;
                            state      <= S_START;
                        end
                    end
                end
                S_START: state <= S_GUARD;
                // core_valid may still be high from the previous run here.
                S_GUARD: state <= S_WAIT;
                S_WAIT: begin
                    if (core_valid) begin
                        res_data  <= core_result;
                        res_err   <= '0;
                        res_valid <= 1'b1;
                        state     <= S_OUT;
                    end else if (expired) begin
                        res_data             <= '0;
                        res_err              <= '0;
                        res_err[ERR_TIMEOUT] <= 1'b1;
                        res_valid            <= 1'b1;
                        state                <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_msg_sequencer.sv
// Self-checking bench for rsa_msg_sequencer with a behavioural modexp core.
module tb_rsa_msg_sequencer;

    localparam int BASE_W  = 6;
    localparam int EXPO_W  = 6;
    localparam int N_W     = 6;
    localparam int TIMEOUT = 68;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              key_load = 1'b0;
    logic [EXPO_W-1:0] key_expo = '0;
    logic [N_W-1:0]    key_n = '0;
    logic              key_err, key_ok;
    logic              msg_valid = 1'b0;
    logic              msg_ready;
    logic [BASE_W-1:0] msg_data = '0;
    logic [BASE_W-1:0] core_base;
    logic [EXPO_W-1:0] core_expo;
    logic [N_W-1:0]    core_n;
    logic              core_start;
    logic [N_W-1:0]    core_result = '0;
    logic              core_valid = 1'b0;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [N_W-1:0]    res_data;
    logic [1:0]        res_err;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference key state
    int ref_e  = 0;
    int ref_n  = 0;
    int ref_ok = 0;

    rsa_msg_sequencer #(
        .BASE_W (BASE_W), .EXPO_W (EXPO_W), .N_W (N_W), .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .key_load (key_load), .key_expo (key_expo), .key_n (key_n),
        .key_err (key_err), .key_ok (key_ok),
        .msg_valid (msg_valid), .msg_ready (msg_ready), .msg_data (msg_data),
        .core_base (core_base), .core_expo (core_expo), .core_n (core_n),
        .core_start (core_start), .core_result (core_result),
        .core_valid (core_valid),
        .res_valid (res_valid), .res_ready (res_ready),
        .res_data (res_data), .res_err (res_err), .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int modexp(input int b, input int e, input int n);
        int r;
        if (n == 0) return 0;
        r = 1 % n;
        for (int i = 0; i < e; i++) r = (r * b) % n;
        return r;
    endfunction

    // Behavioural core: valid rises core_lat cycles after start is seen and
    // stays high until the next start. In hang mode it only shows a stale
    // valid (with a bogus result) through the guard cycle, then never finishes.
    int            core_lat  = 1;
    bit            core_hang = 1'b0;
    int            core_cnt  = 0;
    bit            core_drop = 1'b0;
    int            start_count = 0;
    logic [N_W-1:0] pending = '0;

    always @(posedge clk) begin
        if (core_start) begin
            start_count <= start_count + 1;
            if (core_hang) begin
                core_valid  <= 1'b1;
                core_result <= N_W'(42);
                core_drop   <= 1'b1;
                core_cnt    <= 0;
            end else begin
                core_valid <= 1'b0;
                core_cnt   <= core_lat;
                pending    <= N_W'(modexp(int'(core_base), int'(core_expo), int'(core_n)));
            end
        end else if (core_drop) begin
            core_drop  <= 1'b0;
            core_valid <= 1'b0;
        end else if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) begin
                core_valid  <= 1'b1;
                core_result <= pending;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load a key; in_idle tells the model whether the sequencer is idle.
    task automatic load_key(input int e, input int n, input bit in_idle);
        bit exp_err;
        key_load = 1'b1;
        key_expo = EXPO_W'(e);
        key_n    = N_W'(n);
        #1;
        check("msg_ready_during_key_load", msg_ready, 0);
        step();
        key_load = 1'b0;
        exp_err = !in_idle || (n == 0);
        if (in_idle) begin
            if (n != 0) begin ref_e = e; ref_n = n; ref_ok = 1; end
            else ref_ok = 0;
        end
        check("key_err", key_err, exp_err);
        check("key_ok", key_ok, ref_ok);
        check("core_expo", core_expo, ref_e);
        check("core_n", core_n, ref_n);
        step();
        check("key_err_one_cycle", key_err, 0);
    endtask

    // Send one block and follow it to the result handshake.
    task automatic run_msg(input int m, input int lat, input bit hang,
                           input int hold, input bit kl, output int got_data);
        int         exp_data, exp_err, exp_cyc, exp_starts, cyc, starts0;
        bit         rng;
        rng = (m >= ref_n);
        if (rng) begin
            exp_data = 0; exp_err = 2; exp_cyc = 1;
        end else if (hang || lat > TIMEOUT) begin
            exp_data = 0; exp_err = 1; exp_cyc = 3 + TIMEOUT;
        end else begin
            exp_data = modexp(m, ref_e, ref_n); exp_err = 0; exp_cyc = 3 + lat;
        end
        exp_starts = rng ? 0 : 1;
        core_lat   = lat;
        core_hang  = hang;
        starts0    = start_count;

        check("msg_ready_idle", msg_ready, 1);
        msg_valid = 1'b1;
        msg_data  = BASE_W'(m);
        step();
        msg_valid = 1'b0;
        msg_data  = BASE_W'($urandom);
        cyc = 1;
        check("busy_after_accept", busy, 1);
        check("msg_ready_after_accept", msg_ready, 0);
        check("core_start_cycle1", core_start, !rng);
        if (!rng) check("core_base", core_base, m);
        while (!res_valid && cyc < TIMEOUT + 20) begin
            step();
            cyc++;
            if (cyc == 2) check("core_start_single", core_start, 0);
        end
        check("res_valid_latency", cyc, exp_cyc);
        check("res_valid", res_valid, 1);
        check("res_data", res_data, exp_data);
        check("res_err", res_err, exp_err);
        got_data = int'(res_data);

        for (int i = 0; i < hold; i++) begin
            key_load = kl && (i == 1);
            key_expo = EXPO_W'($urandom);
            key_n    = N_W'($urandom);
            step();
            key_load = 1'b0;
            check("hold_valid", res_valid, 1);
            check("hold_data", res_data, exp_data);
            check("hold_err", res_err, exp_err);
            check("hold_msg_ready", msg_ready, 0);
            check("hold_key_err", key_err, kl && (i == 1));
            check("hold_key_n", core_n, ref_n);
            check("hold_key_ok", key_ok, ref_ok);
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("res_valid_drop", res_valid, 0);
        check("busy_idle", busy, 0);
        check("start_count", start_count - starts0, exp_starts);
    endtask

    initial begin
        int d;
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_key_ok", key_ok, 0);
        check("rst_key_err", key_err, 0);
        check("rst_msg_ready", msg_ready, 0);
        check("rst_core_start", core_start, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_err", res_err, 0);
        check("rst_core_base", core_base, 0);
        check("rst_core_expo", core_expo, 0);
        check("rst_core_n", core_n, 0);
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // Basic run: 4^3 mod 33 = 31
        load_key(3, 33, 1);
        run_msg(4, 5, 0, 2, 0, d);
        check("example_4e3_mod33", d, 31);

        // Exponent zero: N=1 gives 0, N=5 gives 1
        load_key(0, 1, 1);
        run_msg(0, 3, 0, 0, 0, d);
        check("example_e0_n1", d, 0);
        load_key(0, 5, 1);
        run_msg(3, 1, 0, 0, 0, d);
        check("example_e0_n5", d, 1);

        // Range failures and the boundary just below N
        load_key(3, 33, 1);
        run_msg(40, 1, 0, 1, 0, d);
        run_msg(33, 1, 0, 0, 0, d);
        run_msg(32, 2, 0, 0, 0, d);

        // Hung core with stale valid in GUARD, then valid on the last WAIT cycle
        run_msg(5, 1, 1, 0, 0, d);
        run_msg(6, TIMEOUT, 0, 0, 0, d);
        run_msg(7, TIMEOUT + 1, 0, 0, 0, d);

        // Backpressure with a key load attempt while busy
        run_msg(7, 2, 0, 5, 1, d);

        // Randomised traffic
        for (int k = 0; k < 20; k++) begin
            if (k % 5 == 0) load_key($urandom_range(0, 63), $urandom_range(1, 63), 1);
            run_msg($urandom_range(0, 63), $urandom_range(1, 6), 0,
                    $urandom_range(0, 3), $urandom_range(0, 1), d);
        end

        // Reset in the middle of WAIT
        core_hang = 1'b1;
        check("msg_ready_pre_reset", msg_ready, 1);
        msg_valid = 1'b1;
        msg_data  = BASE_W'(1 % ref_n);
        step();
        msg_valid = 1'b0;
        repeat (8) step();
        #3 rst_n = 1'b0;
        #1;
        ref_ok = 0; ref_e = 0; ref_n = 0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_key_ok", key_ok, 0);
        check("mid_rst_res_valid", res_valid, 0);
        check("mid_rst_core_start", core_start, 0);
        check("mid_rst_core_base", core_base, 0);
        check("mid_rst_core_expo", core_expo, 0);
        check("mid_rst_core_n", core_n, 0);
        check("mid_rst_res_err", res_err, 0);
        check("mid_rst_res_data", res_data, 0);
        step();
        rst_n = 1'b1;
        step();
        load_key(9, 0, 1);
        msg_valid = 1'b1;
        #1;
        check("no_key_msg_ready", msg_ready, 0);
        msg_valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rsa_msg_sequencer.md
# rsa_msg_sequencer

Control stage directly upstream of the RSA modular-exponentiation core: holds the public key (exponent, modulus), accepts plaintext blocks over a valid/ready stream, and feeds each block to the core with a single-cycle `core_start` pulse. It then waits for the core's `valid`, captures the result, and presents it downstream over a valid/ready stream. The stage adds range checking, stale-valid protection and a timeout, so the core never runs unsupervised.

## Interface
- `BASE_W`, 6: message/base width; must match the core's `base_width`.
- `EXPO_W`, 6: exponent width; must match the core's `expo_width`.
- `N_W`, 6: modulus/result width; must match the core's `N_width`.
- `TIMEOUT`, 68 (2^EXPO_W+4): maximum WAIT cycles before abort.
- `clk` in 1: single clock; everything is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `key_load` in 1: load key this cycle.
- `key_expo` in EXPO_W: exponent.
- `key_n` in N_W: modulus.
- `key_err` out 1: one-cycle pulse when a key load is rejected.
- `key_ok` out 1: a valid key is held.
- `msg_valid` in 1: upstream block valid.
- `msg_ready` out 1: block accepted when both `msg_valid` and `msg_ready` are high.
- `msg_data` in BASE_W: plaintext block.
- `core_base` out BASE_W: registered base to the core.
- `core_expo` out EXPO_W: registered exponent to the core.
- `core_n` out N_W: registered modulus to the core.
- `core_start` out 1: start/reset pulse to the core.
- `core_result` in N_W: core result.
- `core_valid` in 1: core done.
- `res_valid` out 1: result valid.
- `res_ready` in 1: downstream ready.
- `res_data` out N_W: result.
- `res_err` out 2: bit0 = timeout, bit1 = range; qualified by `res_valid`.
- `busy` out 1: state is not IDLE.

## Operation
- States: IDLE, START, GUARD, WAIT, OUT.
- Key load:
  - `key_load` in IDLE with `key_n` != 0: latch the key and set `key_ok`.
  - `key_load` with `key_n` == 0: reject, pulse `key_err`, clear `key_ok`.
  - `key_load` outside IDLE: ignore and pulse `key_err`; the held key is unchanged.
- `msg_ready` = IDLE & `key_ok` & !`key_load`. A simultaneous key load wins and no message is accepted that cycle.
- On accept:
  - If `msg_data` >= `key_n` (zero-extended compare): skip the core, go to OUT with `res_data`=0 and `res_err`=2'b10.
  - Otherwise: register `core_base`=`msg_data` and go to START.
- START: `core_start`=1 for exactly one cycle, then GUARD.
- GUARD: `core_start`=0. `core_valid` is ignored in this state (it may be stale from the previous run). Go to WAIT.
- WAIT:
  - Timer counts cycles spent in WAIT.
  - On `core_valid`=1: capture `core_result` into `res_data`, set `res_err`=0, go to OUT.
  - If the timer reaches TIMEOUT without `core_valid`: set `res_data`=0, `res_err`=2'b01, go to OUT.
  - If `core_valid` arrives in the same cycle the timer expires, `core_valid` wins.
- OUT: `res_valid`=1. `res_data` and `res_err` stay stable until `res_ready`=1; then return to IDLE.
- `core_expo` and `core_n` are driven from the key registers and stay constant between key loads.
- A key of exponent 0 is legal; the core's own rule applies (result 1, or 0 when N=1).

## Timing
- Reset values: state IDLE; `key_ok`, `key_err`, `msg_ready`, `core_start`, `res_valid` and `busy` all 0; `res_data`, `res_err` and all `core_*` data outputs 0; key registers 0.
- Assertion of `rst_n` in any state aborts immediately. The key is lost and must be reloaded.
- Accept at cycle 0:
  - `core_start` is high in cycle 1.
  - GUARD is cycle 2.
  - `core_valid` is first sampled in cycle 3.
  - `res_valid` rises the cycle after `core_valid` is sampled high.
- Range-fail path: `res_valid` rises in cycle 1.
- Throughput: one block in flight; `msg_ready` is low from accept until the OUT handshake completes.
- No combinational path from `res_ready` or `core_valid` to any output except through the state registers. `msg_ready` depends combinationally on `key_load`.

## Structure
- Shared package `rsa_pkg`:
  - state enum,
  - `res_err` bit indices,
  - TIMEOUT default expression.
- Sub-module `rsa_seq_timer`: WAIT-cycle counter with clear and `expired` outputs, width $clog2(TIMEOUT+1).

## Test plan
- Key e=3, N=33; msg 4 with a behavioural core → `core_start` pulses once, `res_data`=31, `res_err`=00, `res_valid` held until `res_ready`.
- Key e=0, N=1; msg 0 → `res_data`=0, `res_err`=00. Then key e=0, N=5; msg 3 → `res_data`=1.
- Key e=3, N=33; msg 40 → no `core_start`, `res_valid` in cycle 1, `res_data`=0, `res_err`=10.
- Stub core that never asserts valid (and holds stale valid=1 during GUARD) → `res_err`=01 exactly TIMEOUT cycles after WAIT entry. The stale valid must not be captured.
- Backpressure: `res_ready` low for 5 cycles → `res_data` and `res_err` stable, `msg_ready`=0. `key_load` during this time → `key_err` pulse, key unchanged.
- `rst_n` low mid-WAIT → all outputs at reset values asynchronously, `key_ok`=0. `key_load` with N=0 → `key_err` pulse, `key_ok` stays 0.
